// File: rtl/regfile_sb_if.sv
// Bus interface for regfile_sb.
// Groups the read ports, the write port, the scoreboard issue port and the
// soft-clear request/status.
//   master : requester side (drives addresses, write data, issue, SCLR)
//   slave  : register file side (drives RDATA1/2, BUSY1/2, CLEAR_BUSY)
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   RADDR1;
  logic [AW-1:0]   RADDR2;
  logic [XLEN-1:0] RDATA1;
  logic [XLEN-1:0] RDATA2;
  logic            WEN;
  logic [AW-1:0]   WADDR;
  logic [XLEN-1:0] WDATA;
  logic            ISSUE_EN;
  logic [AW-1:0]   ISSUE_ADDR;
  logic            BUSY1;
  logic            BUSY2;
  logic            SCLR;
  logic            CLEAR_BUSY;

  modport master (
    output RADDR1, RADDR2, WEN, WADDR, WDATA, ISSUE_EN, ISSUE_ADDR, SCLR,
    input  RDATA1, RDATA2, BUSY1, BUSY2, CLEAR_BUSY
  );

  modport slave (
    input  RADDR1, RADDR2, WEN, WADDR, WDATA, ISSUE_EN, ISSUE_ADDR, SCLR,
    output RDATA1, RDATA2, BUSY1, BUSY2, CLEAR_BUSY
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with scoreboard and soft-clear sweep.
// Two combinational read ports with same-cycle write bypass, one write port,
// per-register pending bits, and a sequential engine that zeroes r1..rNREG-1
// one register per cycle after a SCLR pulse.
// Ports:
//   CLK   : rising-edge clock
//   RESET : asynchronous active-low reset (clears array, pending bits, FSM)
//   bus   : regfile_sb_if slave modport (read/write/issue/soft-clear signals)
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] pend_q;

  logic            idle;
  logic            wr_ok;
  logic            iss_ok;
  logic            byp1;
  logic            byp2;

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.SCLR) begin
          state_d = SWEEP;
          idx_d   = AW'(1);
        end
      end
      SWEEP: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREG - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    idle           = (state_q == IDLE);
    bus.CLEAR_BUSY = (state_q == SWEEP);
  end

  // Requests are only honoured while idle; register 0 is never a target.
  assign wr_ok  = idle && bus.WEN      && (bus.WADDR      != '0);
  assign iss_ok = idle && bus.ISSUE_EN && (bus.ISSUE_ADDR != '0);

  // Array and scoreboard. mem_q[0] / pend_q[0] are never written after reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
    end else if (state_q == SWEEP) begin
      mem_q[idx_q]  <= '0;
      pend_q[idx_q] <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[bus.WADDR]  <= bus.WDATA;
        pend_q[bus.WADDR] <= 1'b0;
      end
      // Placed after the write so a new producer overrides a completing one.
      if (iss_ok) begin
        pend_q[bus.ISSUE_ADDR] <= 1'b1;
      end
    end
  end

  // Read ports: x0 forced to zero, bypass only while idle.
  assign byp1 = idle && bus.WEN && (bus.WADDR == bus.RADDR1) && (bus.RADDR1 != '0);
  assign byp2 = idle && bus.WEN && (bus.WADDR == bus.RADDR2) && (bus.RADDR2 != '0);

  always_comb begin
    bus.RDATA1 = '0;
    bus.RDATA2 = '0;
    if (bus.RADDR1 != '0) begin
      bus.RDATA1 = byp1 ? bus.WDATA : mem_q[bus.RADDR1];
    end
    if (bus.RADDR2 != '0) begin
      bus.RDATA2 = byp2 ? bus.WDATA : mem_q[bus.RADDR2];
    end
  end

  assign bus.BUSY1 = pend_q[bus.RADDR1] && !byp1;
  assign bus.BUSY2 = pend_q[bus.RADDR2] && !byp2;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the pipeline's decode/writeback stages. Two read ports and one write port, with x0 hardwired to zero and write-to-read bypass in the same cycle. A per-register scoreboard (pending bits) supports hazard detection. A sequential soft-clear engine zeroes the file one register per cycle without asserting reset.

## Interface
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 4; AW = log2(NREG) address bits.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RADDR1, RADDR2  in  AW  read addresses.
- RDATA1, RDATA2  out  XLEN  read data; combinational.
- WEN  in  1  write enable.
- WADDR  in  AW  write address.
- WDATA  in  XLEN  write data.
- ISSUE_EN  in  1  mark the destination register as pending.
- ISSUE_ADDR  in  AW  destination register being issued.
- BUSY1, BUSY2  out  1  pending flag for RADDR1/RADDR2, after bypass.
- SCLR  in  1  soft-clear request; single-cycle pulse.
- CLEAR_BUSY  out  1  high while the clear sweep is running.

## Operation
- Storage is NREG x XLEN flops plus NREG pending bits.
- Register 0 always reads 0 and is never pending.
  - WEN or ISSUE_EN targeting register 0 has no effect.
- Read path, evaluated independently for each port n:
  - If RADDRn = 0, RDATAn = 0.
  - Otherwise, if WEN, WADDR = RADDRn and FSM is IDLE, RDATAn = WDATA (bypass).
  - Otherwise, RDATAn = mem[RADDRn].
- Write: on a clock edge with WEN, WADDR != 0 and FSM IDLE:
  - mem[WADDR] takes WDATA.
  - pending[WADDR] is cleared.
- Issue: on a clock edge with ISSUE_EN, ISSUE_ADDR != 0 and FSM IDLE, pending[ISSUE_ADDR] is set.
- Issue and write to the same address on the same edge: set wins. The new producer supersedes the completing one, so pending stays 1 and mem still takes WDATA.
- BUSYn = pending[RADDRn] AND NOT (WEN AND WADDR = RADDRn AND RADDRn != 0 AND FSM IDLE).
- Soft-clear FSM, two states:
  - IDLE: SCLR=1 moves to SWEEP and loads idx = 1. Otherwise stays in IDLE.
  - SWEEP: each edge sets mem[idx] = 0, pending[idx] = 0 and increments idx. On the edge where idx = NREG-1, return to IDLE.
  - SCLR is ignored in SWEEP.
  - WEN and ISSUE_EN are ignored in SWEEP. The requester must stall on CLEAR_BUSY.
  - Reads during SWEEP return current array contents, which may be partially cleared. Bypass is disabled.
- CLEAR_BUSY = (state = SWEEP).
- Asynchronous RESET low, any time including mid-sweep:
  - All mem to 0, all pending to 0, FSM to IDLE, idx to 0.
  - Effect is immediate, not clock-gated.
  - Writes and issues are blocked while RESET is low.
- Reset values of outputs: RDATA1/2 = 0, BUSY1/2 = 0, CLEAR_BUSY = 0.

## Timing
- Read latency 0 cycles, combinational from address/bypass inputs.
- Write visible through the array from the cycle after the edge. Visible the same cycle via bypass.
- Pending set is visible on BUSYn from the cycle after the ISSUE_EN edge.
- Sweep duration: exactly NREG-1 cycles with CLEAR_BUSY high (31 for NREG=32). It starts the cycle after the SCLR edge.
- First edge after RESET deasserts: normal operation, no recovery cycles.
- No handshake on WEN/ISSUE_EN; they are single-cycle qualified by FSM IDLE.

## Test plan
- Reset and x0:
  - Assert RESET=0, then release.
  - All reads return 0 and BUSY = 0.
  - Write WADDR=0, WDATA=0xDEADBEEF; RADDR1=0 still reads 0.
- Bypass:
  - WEN=1, WADDR=5, WDATA=0x0000005F, RADDR1=5 in the same cycle.
  - RDATA1 = 0x5F before the edge and stays 0x5F after it with WEN=0.
- Scoreboard:
  - ISSUE_EN on r7; next cycle RADDR2=7 gives BUSY2=1.
  - Write r7=28: BUSY2=0 in the write cycle, RDATA2=28.
  - Issue and write r7 on the same edge: BUSY2=1 afterwards, mem[7]=28.
- Soft clear:
  - Fill r1..r31 with values i*3 and set pending on r9.
  - Pulse SCLR: CLEAR_BUSY is high for 31 cycles.
  - A WEN r4=0x77 mid-sweep is ignored.
  - Afterwards all registers read 0 and BUSY=0.
- Reset mid-sweep:
  - Pull RESET low at sweep cycle 10.
  - CLEAR_BUSY drops immediately and all registers read 0.
  - After release, a write of r3=6 reads back 6.
- Parameter sweep:
  - NREG=8, XLEN=16: write r7=0xFFFF and read it back.
  - SCLR sweep lasts 7 cycles.
